// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake, {V,N,Z} flags and a k-step shift-add multiply
module alu_seq #(
  parameter int k = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [k-1:0] ain,
  input  logic [k-1:0] bin,
  output logic [k-1:0] out,
  output logic [2:0]   status,
  output logic         busy,
  output logic         done
);
  localparam int cw = $clog2(k);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [k-1:0] mcand, mcand_n, mplier, mplier_n, out_n, res, asr;
  logic [2*k-1:0] acc, acc_n, prod;
  logic [cw-1:0] cnt, cnt_n, sh;
  logic [2:0] status_n;
  logic busy_n, done_n, v;
  assign sh = bin[cw-1:0];
  assign asr = $signed(ain) >>> sh;
  // single-cycle result and overflow flag; MUL has its own path through the accumulator
  always_comb begin
    res = op == 3'd0 ? ain + bin :
          op == 3'd1 ? ain - bin :
          op == 3'd2 ? ain & bin :
          op == 3'd3 ? ain :
          op == 3'd5 ? ain << sh :
          op == 3'd6 ? ain >> sh :
          op == 3'd7 ? asr : '0;
    v = op == 3'd0 ? (ain[k-1] == bin[k-1]) && (res[k-1] != ain[k-1]) :
        op == 3'd1 ? (ain[k-1] != bin[k-1]) && (res[k-1] != ain[k-1]) : 1'b0;
  end
  // next-state: issue in IDLE, one shift-add step per edge in MUL, complete on the last step
  always_comb begin
    state_n  = state;
    out_n    = out;
    status_n = status;
    busy_n   = busy;
    done_n   = 1'b0;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    prod     = acc + (mplier[cnt] ? {{k{1'b0}}, mcand} << cnt : '0);
    if (state == IDLE && start && op == 3'd4) begin
      mcand_n  = ain;
      mplier_n = bin;
      acc_n    = '0;
      cnt_n    = '0;
      busy_n   = 1'b1;
      state_n  = MUL;
    end else if (state == IDLE && start) begin
      out_n    = res;
      status_n = {v, res[k-1], res == '0};
      done_n   = 1'b1;
    end else if (state == MUL) begin
      acc_n = prod;
      cnt_n = cnt + 1'b1;
      if (cnt == cw'(k - 1)) begin
        out_n    = prod[k-1:0];
        status_n = {|prod[2*k-1:k], prod[k-1], prod[k-1:0] == '0};
        done_n   = 1'b1;
        busy_n   = 1'b0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
    end
  end
  // state and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      out    <= '0;
      status <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      out    <= out_n;
      status <= status_n;
      busy   <= busy_n;
      done   <= done_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy, done;
  logic [2:0] op = '0, status;
  logic [15:0] ain = '0, bin = '0, out;
  int cyc = 0, mul_n = -1, errors = 0, checks = 0;
  typedef struct {int c; logic [15:0] o; logic [2:0] s;} exp_t;
  exp_t q[$];
  alu_seq #(.k(16)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .ain(ain), .bin(bin),
                         .out(out), .status(status), .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // result and flags straight from the op definitions, using wide integer arithmetic
  function automatic logic [18:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    logic [15:0] r;
    logic v;
    int sh;
    sh = int'(b % 16);
    v = 1'b0;
    full = 32'(a) * 32'(b);
    case (o)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = a;
      3'd4: begin r = full[15:0]; v = full[31:16] != 0; end
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: r = 16'($signed(a) >>> sh);
    endcase
    return {v, r[15], r == 16'h0, r};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int n;
    n = cyc + 1;
    e.c = (o == 3'd4) ? n + 16 : n;
    {e.s, e.o} = model(o, a, b);
    q.push_back(e);
    if (o == 3'd4) mul_n = n;
    start = 1'b1; op = o; ain = a; bin = b;
    tick();
    if (o == 3'd4)
      repeat (16) begin
        op = 3'($urandom); ain = 16'($urandom); bin = 16'($urandom);
        tick();
      end
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) tick();
  endtask
  // monitor: busy window and done timing against the bench's own bookkeeping, values from the queue
  always @(negedge clk) begin
    automatic logic exp_busy = mul_n >= 0 && cyc >= mul_n && cyc < mul_n + 16;
    automatic logic exp_done;
    exp_t e;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    while (q.size() > 0 && q[0].c < cyc) begin
      e = q.pop_front();
      errors++;
      $display("FAIL lost_done exp_cyc=%0d now=%0d", e.c, cyc);
    end
    exp_done = q.size() > 0 && q[0].c == cyc;
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
    end
    if (exp_done) begin
      e = q.pop_front();
      checks++;
      if (out !== e.o || status !== e.s) begin
        errors++;
        $display("FAIL result cyc=%0d got out=%h status=%b exp out=%h status=%b", cyc, out, status, e.o, e.s);
      end
    end
  end
  task automatic check_zero(input string name);
    checks++;
    if (out !== 16'h0 || status !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got out=%h status=%b busy=%b done=%b exp all zero", name, out, status, busy, done);
    end
  endtask
  initial begin
    #1 check_zero("reset_state");
    tick(); tick();
    reset = 1'b0;
    issue(3'd0, 16'h7FFF, 16'h0001);
    idle(2);
    issue(3'd1, 16'h1234, 16'h1234);
    issue(3'd1, 16'h8000, 16'h0001);
    idle(1);
    issue(3'd4, 16'h0003, 16'h0005);
    issue(3'd4, 16'h0100, 16'h0100);
    issue(3'd4, 16'hFFFF, 16'h0000);
    idle(1);
    issue(3'd5, 16'h0001, 16'd15);
    issue(3'd7, 16'h8000, 16'd3);
    issue(3'd6, 16'h8000, 16'd3);
    issue(3'd3, 16'hABCD, 16'h0000);
    idle(2);
    mul_n = cyc + 1;
    start = 1'b1; op = 3'd4; ain = 16'h0003; bin = 16'h0005;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 reset = 1'b1;
    mul_n = -1;
    #1 check_zero("reset_mid_mul");
    tick();
    reset = 1'b0;
    idle(1);
    issue(3'd0, 16'h0002, 16'h0002);
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the lab datapath ALU: it adds registered results, a start/busy/done handshake, a wider op set, an iterative multi-cycle unsigned multiply, and a 3-bit status word {V,N,Z}. It sits between the register file operand latches and the writeback mux. The controller FSM issues one operation at a time and waits for `done` before writeback.

## Interface
- `k`, default 16: datapath width in bits; must be at least 2.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `start` input, 1 bit: request an operation. Sampled only when `busy`=0.
- `op` input, 3 bits: operation select, sampled with `start`.
- `ain` input, k bits: operand A, sampled with `start`.
- `bin` input, k bits: operand B, sampled with `start`.
- `out` output, k bits: registered result; holds its value between operations.
- `status` output, 3 bits: registered {V,N,Z} flags, updated together with `out`.
- `busy` output, 1 bit: high while a multiply is in progress.
- `done` output, 1 bit: one-cycle pulse, high in the cycle after `out`/`status` are written.

## Operation
- Op encoding:
  - 000: ADD, ain+bin
  - 001: SUB, ain−bin
  - 010: AND, ain&bin
  - 011: MOV, ain
  - 100: MUL, low k bits of unsigned ain*bin
  - 101: SHL, ain<<bin[$clog2(k)-1:0]
  - 110: SHR, logical right shift by the same amount
  - 111: ASR, arithmetic right shift by the same amount
- All arithmetic is modulo 2^k. There is no carry output.
- Flags:
  - Z = (result==0).
  - N = result[k-1].
  - V for ADD = (ain[k-1]==bin[k-1]) && (result[k-1]!=ain[k-1]).
  - V for SUB = (ain[k-1]!=bin[k-1]) && (result[k-1]!=ain[k-1]).
  - V for MUL = 1 if the upper k bits of the full 2k-bit product are non-zero.
  - V = 0 for every other op.
- FSM states are IDLE and MUL.
  - IDLE, `start`=1, op≠100: compute combinationally, write `out` and `status`, set `done`=1. Stay in IDLE.
  - IDLE, `start`=1, op=100: latch multiplicand, multiplier and a cleared 2k-bit accumulator, set iteration counter to 0, `busy`=1. Go to MUL.
  - MUL: each edge performs one shift-add step on multiplier bit [counter] and increments the counter.
  - MUL, on the step where counter==k-1: write `out` = accumulator low half, write `status`, `done`=1, `busy`=0. Go to IDLE.
- A multiply always takes exactly k steps, regardless of operand values (including zero operands).
- `start` while `busy`=1 is ignored. `op`, `ain` and `bin` changes during MUL have no effect, because operands are latched.
- `done` is cleared on every edge where no completion occurs.

## Timing
- Reset values: `out`=0, `status`=000, `busy`=0, `done`=0, state IDLE, counter 0, accumulator 0.
- Reset takes effect immediately, without waiting for a clock edge. Reset during MUL aborts the operation, discards the partial product and produces no `done` pulse.
- Single-cycle ops: `start` sampled at edge N; `out`/`status` valid and `done`=1 after edge N; `done` low after edge N+1 unless another op completes there. Latency is 1.
- MUL: `start` sampled at edge N; `busy`=1 after edge N; steps occur at edges N+1 … N+k. Result, `done`=1 and `busy`=0 all appear after edge N+k. Latency is k+1 edges.
- Back-to-back: `start` is accepted in any cycle where `busy`=0, including the cycle where `done`=1. This gives one single-cycle op per clock.
- `busy` is never high in the same cycle as a single-cycle `done`.

## Test plan
- **Reset then ADD:** reset, then ADD 0x7FFF+0x0001 → after 1 edge `out`=0x8000, status {V,N,Z}=110, `done` pulses for one cycle.
- **SUB to zero:** SUB 0x1234−0x1234 → `out`=0x0000, status=001. **Signed overflow:** SUB 0x8000−0x0001 → `out`=0x7FFF, status=100.
- **MUL:** 0x0003*0x0005 → `busy` high for 16 cycles, `out`=0x000F, status=000 after edge N+16, single `done` pulse. A `start` issued while busy with different operands is ignored.
- **MUL overflow:** 0x0100*0x0100 → `out`=0x0000, status=101. Also 0xFFFF*0x0000 → still 16 cycles, status=001.
- **Shifts and back-to-back:** issue SHL 0x0001 by 15, ASR 0x8000 by 3, SHR 0x8000 by 3, MOV 0xABCD on four consecutive cycles → outputs 0x8000, 0xF000, 0x1000, 0xABCD; `done` is high for 4 consecutive cycles.
- **Reset mid-MUL:** assert `reset` at cycle 7 of a MUL → `busy`=0 and `out`=0 immediately, no `done` pulse. A following ADD 2+2 → `out`=0x0004.
